// File: rtl/mc_core_ctrl.sv
// Multi-cycle core sequencer: fetch/exec/mem/writeback handshakes, wait-timeout,
// terminal halt/fault states and cycle/instret performance counters.
module mc_core_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              TIMEOUT  = 255,
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_reg_wen,
    input  logic             dec_halt,
    input  logic [XLEN-1:0]  next_pc,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             dmem_rvalid,
    output logic             rf_wen,
    output logic [XLEN-1:0]  pc,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_IWAIT = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_MWAIT = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    // The wait counter only needs to reach TIMEOUT-1: that cycle either succeeds or faults.
    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q,   state_d;
    logic [XLEN-1:0]  pc_q,      pc_d;
    logic [31:0]      inst_q,    inst_d;
    logic [CNT_W-1:0] cycle_q,   cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [WAIT_W-1:0] wait_q,   wait_d;
    logic             timeout_s;
    logic             wait_state_s;
    logic             pc_aligned_s;

    assign timeout_s    = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
    assign wait_state_s = (state_q == S_FETCH) || (state_q == S_IWAIT) ||
                          (state_q == S_MEM)   || (state_q == S_MWAIT);
    assign pc_aligned_s = (next_pc[1:0] == 2'b00);

    // Next-state, instruction latch, PC and retirement logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    if (imem_rvalid) begin
                        inst_d  = imem_rdata;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_IWAIT;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_IWAIT: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_EXEC;
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_IWAIT;
                end
            end
            S_EXEC: begin
                if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_mem_rd && dec_mem_wr) begin
                    state_d = S_ERR;
                end else if (dec_mem_rd || dec_mem_wr) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (dec_mem_wr || dmem_rvalid) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_MWAIT;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MWAIT: begin
                if (dmem_rvalid) begin
                    state_d = S_WB;
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_MWAIT;
                end
            end
            S_WB: begin
                // A misaligned target faults without retiring or moving the PC.
                if (pc_aligned_s) begin
                    pc_d      = next_pc;
                    instret_d = instret_q + CNT_ONE;
                    state_d   = S_FETCH;
                end else begin
                    state_d   = S_ERR;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // Cycle counter and per-state wait counter.
    always_comb begin
        if ((state_q == S_HALT) || (state_q == S_ERR)) begin
            cycle_d = cycle_q;
        end else begin
            cycle_d = cycle_q + CNT_ONE;
        end
        if (state_d != state_q) begin
            wait_d = {WAIT_W{1'b0}};
        end else if (wait_state_s) begin
            wait_d = wait_q + WAIT_ONE;
        end else begin
            wait_d = wait_q;
        end
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0000_0000;
            cycle_q   <= {CNT_W{1'b0}};
            instret_q <= {CNT_W{1'b0}};
            wait_q    <= {WAIT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign inst      = inst_q;
    assign dmem_req  = (state_q == S_MEM);
    assign dmem_we   = (state_q == S_MEM) && dec_mem_wr;
    assign rf_wen    = (state_q == S_WB) && dec_reg_wen && pc_aligned_s;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign err       = (state_q == S_ERR);
    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;

endmodule
